t2_affine_mcm_pipe: RTL and testbench

- Pipelined, parametrised successor to the tap-2 MCM block of the 1/16-precision affine interpolation filter.
- Takes one signed sample plus a 4-bit fractional phase per transfer. Returns the single tap-2 product for that phase.
- Uses shared shift-add terms, with no multipliers.
- Sits between the reference-sample fetch stage and the 8-tap accumulator, using valid/ready streams on both sides.

---
 rtl/affine_filter_pkg.sv | 27 ++
 rtl/t2_mcm_terms.sv | 34 +++
 rtl/t2_affine_mcm_pipe.sv | 113 +++++++++++
 tb/tb_t2_affine_mcm_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/affine_filter_pkg.sv
// Shared constants, coefficient tables and helpers for the 1/16-precision affine interpolation filter.
package affine_filter_pkg;

    localparam int FRAC_W      = 4;
    localparam int NUM_TERMS   = 10;
    localparam int COEF_T2_MAX = 63;

    localparam int COEF_T2 [16] = '{0, 63, 62, 60, 58, 52, 47, 45, 40, 34, 31, 26, 17, 13, 8, 4};

    typedef enum logic [3:0] {
        TERM_1,
        TERM_5,
        TERM_13,
        TERM_15,
        TERM_17,
        TERM_29,
        TERM_31,
        TERM_45,
        TERM_47,
        TERM_63
    } term_e;

    function automatic int prodWidth(input int dataW, input int maxCoef);
        return dataW + $clog2(maxCoef + 1);
    endfunction

endpackage

// File: rtl/t2_mcm_terms.sv
// Combinational shift-add generation of the ten shared tap-2 multiples of x.
module t2_mcm_terms
    import affine_filter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int W      = DATA_W + 6
) (
    input  logic signed [DATA_W-1:0] x_i,
    output logic signed [W-1:0]      terms_o [NUM_TERMS]
);

    logic signed [W-1:0] xExt;
    logic signed [W-1:0] t5;
    logic signed [W-1:0] t15;

    assign xExt = {{(W-DATA_W){x_i[DATA_W-1]}}, x_i};
    assign t5   = xExt + (xExt <<< 2);
    assign t15  = (xExt <<< 4) - xExt;

    // Odd multiples only; even coefficients are formed by shifting these in the select stage.
    always_comb begin
        terms_o[TERM_1]  = xExt;
        terms_o[TERM_5]  = t5;
        terms_o[TERM_13] = t5 + (xExt <<< 3);
        terms_o[TERM_15] = t15;
        terms_o[TERM_17] = (xExt <<< 4) + xExt;
        terms_o[TERM_29] = (t15 <<< 1) - xExt;
        terms_o[TERM_31] = (xExt <<< 5) - xExt;
        terms_o[TERM_45] = t5 + (t5 <<< 3);
        terms_o[TERM_47] = t15 + (xExt <<< 5);
        terms_o[TERM_63] = (xExt <<< 6) - xExt;
    end

endmodule

// File: rtl/t2_affine_mcm_pipe.sv
// Two-stage valid/ready pipelined multiplierless tap-2 product: x * COEF_T2[frac], optionally negated.
module t2_affine_mcm_pipe
    import affine_filter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = prodWidth(DATA_W, COEF_T2_MAX),
    parameter bit NEGATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic [FRAC_W-1:0]        in_frac,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_y,
    output logic [FRAC_W-1:0]        out_frac
);

    logic signed [OUT_W-1:0] termsD [NUM_TERMS];
    logic signed [OUT_W-1:0] s1Terms_q [NUM_TERMS];
    logic [FRAC_W-1:0]       s1Frac_q;
    logic                    s1Valid_q, s1Valid_d;
    logic signed [OUT_W-1:0] s2Y_q, prod_d;
    logic [FRAC_W-1:0]       s2Frac_q;
    logic                    s2Valid_q, s2Valid_d;
    logic signed [OUT_W-1:0] selProd;
    logic                    s1Adv, s1Load, s2Load;

    t2_mcm_terms #(
        .DATA_W (DATA_W),
        .W      (OUT_W)
    ) uTerms (
        .x_i     (in_x),
        .terms_o (termsD)
    );

    assign s1Adv    = !s2Valid_q || out_ready;
    assign in_ready = !flush && (!s1Valid_q || s1Adv);
    assign s1Load   = in_valid && in_ready;
    assign s2Load   = s1Valid_q && s1Adv && !flush;

    always_comb begin
        s1Valid_d = s1Valid_q;
        s2Valid_d = s2Valid_q;
        if (flush) begin
            s1Valid_d = 1'b0;
            s2Valid_d = 1'b0;
        end else begin
            if (s1Adv) s2Valid_d = s1Valid_q;
            if (in_ready) s1Valid_d = in_valid;
        end
    end

    always_comb begin
        selProd = '0;
        case (s1Frac_q)
            4'd1:    selProd = s1Terms_q[TERM_63];
            4'd2:    selProd = s1Terms_q[TERM_31] <<< 1;
            4'd3:    selProd = s1Terms_q[TERM_15] <<< 2;
            4'd4:    selProd = s1Terms_q[TERM_29] <<< 1;
            4'd5:    selProd = s1Terms_q[TERM_13] <<< 2;
            4'd6:    selProd = s1Terms_q[TERM_47];
            4'd7:    selProd = s1Terms_q[TERM_45];
            4'd8:    selProd = s1Terms_q[TERM_5] <<< 3;
            4'd9:    selProd = s1Terms_q[TERM_17] <<< 1;
            4'd10:   selProd = s1Terms_q[TERM_31];
            4'd11:   selProd = s1Terms_q[TERM_13] <<< 1;
            4'd12:   selProd = s1Terms_q[TERM_17];
            4'd13:   selProd = s1Terms_q[TERM_13];
            4'd14:   selProd = s1Terms_q[TERM_1] <<< 3;
            4'd15:   selProd = s1Terms_q[TERM_1] <<< 2;
            default: selProd = '0;
        endcase
        prod_d = NEGATE ? -selProd : selProd;
    end

    // Data registers only move on their stage enable so outputs stay quiet while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1Frac_q  <= '0;
            for (int i = 0; i < NUM_TERMS; i++) s1Terms_q[i] <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            if (s1Load) begin
                s1Frac_q  <= in_frac;
                s1Terms_q <= termsD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid_q <= 1'b0;
            s2Y_q     <= '0;
            s2Frac_q  <= '0;
        end else begin
            s2Valid_q <= s2Valid_d;
            if (s2Load) begin
                s2Y_q    <= prod_d;
                s2Frac_q <= s1Frac_q;
            end
        end
    end

    assign out_valid = s2Valid_q;
    assign out_y     = s2Y_q;
    assign out_frac  = s2Frac_q;

endmodule

// File: tb/tb_t2_affine_mcm_pipe.sv
// Self-checking bench: directed vector table, stall/flush/reset sequences, randomized DATA_W=10 run vs a queue model.
module tb_t2_affine_mcm_pipe;

    localparam int N_VEC = 22;

    typedef struct {
        logic signed [7:0] x;
        logic [3:0]        frac;
        longint            y;
    } vec_t;

    typedef struct {
        longint y;
        int     f;
    } exp_t;

    int coefRef [16] = '{0, 63, 62, 60, 58, 52, 47, 45, 40, 34, 31, 26, 17, 13, 8, 4};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              inValid, outReady;
    logic signed [7:0] inX;
    logic [3:0]        inFrac;
    logic              inReady, outValid, inReadyN, outValidN;
    logic signed [13:0] outY, outYN;
    logic [3:0]        outFrac, outFracN;

    logic               rInValid, rOutReady, rInReady, rOutValid;
    logic signed [9:0]  rInX;
    logic [3:0]         rInFrac, rOutFrac;
    logic signed [15:0] rOutY;

    int checks = 0;
    int failures = 0;
    vec_t vecs [N_VEC];
    exp_t expQ [$];

    always #5 clk = ~clk;

    t2_affine_mcm_pipe #(.DATA_W(8), .NEGATE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_x(inX), .in_frac(inFrac),
        .out_valid(outValid), .out_ready(outReady), .out_y(outY), .out_frac(outFrac)
    );

    t2_affine_mcm_pipe #(.DATA_W(8), .NEGATE(1'b1)) dutNeg (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(inValid), .in_ready(inReadyN), .in_x(inX), .in_frac(inFrac),
        .out_valid(outValidN), .out_ready(outReady), .out_y(outYN), .out_frac(outFracN)
    );

    t2_affine_mcm_pipe #(.DATA_W(10), .NEGATE(1'b0)) dut10 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(rInValid), .in_ready(rInReady), .in_x(rInX), .in_frac(rInFrac),
        .out_valid(rOutValid), .out_ready(rOutReady), .out_y(rOutY), .out_frac(rOutFrac)
    );

    function automatic longint refY(input longint x, input int f);
        return x * coefRef[f];
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic signed [7:0] x, input logic [3:0] f, input logic rdy);
        inValid  = v;
        inX      = x;
        inFrac   = f;
        outReady = rdy;
        #1;
    endtask

    // One randomized (or draining) cycle on the DATA_W=10 instance, scored against the queue model.
    logic   prevStall = 1'b0;
    longint prevY = 0;
    int     nIn = 0, nOut = 0;

    task automatic randCycle(input bit drain);
        rInValid  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
        rInX      = 10'($urandom);
        rInFrac   = 4'($urandom);
        rOutReady = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
        #1;
        if (prevStall) begin
            checkOutput("rand_stall_valid", rOutValid, 1);
            checkOutput("rand_stall_hold", rOutY, prevY);
        end
        if (rOutValid && rOutReady) begin
            nOut++;
            if (expQ.size() == 0) begin
                checkOutput("rand_unexpected_out", nOut, nIn);
            end else begin
                exp_t e = expQ.pop_front();
                checkOutput("rand_y", rOutY, e.y);
                checkOutput("rand_frac", rOutFrac, e.f);
            end
        end
        if (rInValid && rInReady) begin
            exp_t e;
            e.y = refY(rInX, rInFrac);
            e.f = rInFrac;
            expQ.push_back(e);
            nIn++;
        end
        prevStall = rOutValid && !rOutReady;
        prevY     = rOutY;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        inValid = 1'b0; inX = '0; inFrac = '0; outReady = 1'b0;
        rInValid = 1'b0; rInX = '0; rInFrac = '0; rOutReady = 1'b0;

        for (int i = 0; i < 16; i++) begin
            vecs[i].x = 8'sd1;
            vecs[i].frac = 4'(i);
        end
        vecs[0].y = 0;  vecs[1].y = 63; vecs[2].y = 62;  vecs[3].y = 60;
        vecs[4].y = 58; vecs[5].y = 52; vecs[6].y = 47;  vecs[7].y = 45;
        vecs[8].y = 40; vecs[9].y = 34; vecs[10].y = 31; vecs[11].y = 26;
        vecs[12].y = 17; vecs[13].y = 13; vecs[14].y = 8; vecs[15].y = 4;
        vecs[16] = '{-8'sd128, 4'd1, -8064};
        vecs[17] = '{8'sd127, 4'd6, 5969};
        vecs[18] = '{-8'sd1, 4'd15, -4};
        vecs[19] = '{8'sd100, 4'd9, 3400};
        vecs[20] = '{-8'sd77, 4'd12, -1309};
        vecs[21] = '{8'sd45, 4'd13, 585};

        #22;
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_out_y", outY, 0);
        checkOutput("rst_out_frac", outFrac, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("rst_in_ready", inReady, 1);
        checkOutput("rst_in_ready_neg", inReadyN, 1);

        // Back-to-back table: result for vector c-1 must appear right after the edge following its accept.
        for (int c = 0; c <= N_VEC; c++) begin
            if (c < N_VEC) applyStimulus(1'b1, vecs[c].x, vecs[c].frac, 1'b1);
            else           applyStimulus(1'b0, '0, '0, 1'b1);
            if (c < N_VEC) checkOutput("tbl_in_ready", inReady, 1);
            tick();
            if (c == 0) begin
                checkOutput("tbl_latency", outValid, 0);
            end else begin
                checkOutput("tbl_out_valid", outValid, 1);
                checkOutput("tbl_out_y", outY, vecs[c-1].y);
                checkOutput("tbl_out_frac", outFrac, vecs[c-1].frac);
                checkOutput("tbl_neg_y", outYN, -vecs[c-1].y);
            end
        end
        applyStimulus(1'b0, '0, '0, 1'b1);
        tick();
        checkOutput("tbl_drained", outValid, 0);

        // Backpressure: two items enter, third waits while output is stalled.
        applyStimulus(1'b1, 8'sd3, 4'd4, 1'b0);
        checkOutput("bp_accept0", inReady, 1);
        tick();
        applyStimulus(1'b1, 8'sd5, 4'd4, 1'b0);
        checkOutput("bp_accept1", inReady, 1);
        tick();
        applyStimulus(1'b1, 8'sd7, 4'd4, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_in_ready_low", inReady, 0);
            checkOutput("bp_valid_held", outValid, 1);
            checkOutput("bp_y_held", outY, 174);
            checkOutput("bp_frac_held", outFrac, 4);
            tick();
        end
        applyStimulus(1'b1, 8'sd7, 4'd4, 1'b1);
        checkOutput("bp_release_ready", inReady, 1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("bp_second_valid", outValid, 1);
        checkOutput("bp_second_y", outY, 290);
        tick();
        checkOutput("bp_third_y", outY, 406);
        tick();
        checkOutput("bp_empty", outValid, 0);

        // Flush with two items in flight, plus an input offered during the flush cycle.
        applyStimulus(1'b1, 8'sd1, 4'd1, 1'b1);
        tick();
        applyStimulus(1'b1, 8'sd2, 4'd2, 1'b1);
        tick();
        flush = 1'b1;
        applyStimulus(1'b1, 8'sd9, 4'd3, 1'b1);
        checkOutput("fl_in_ready", inReady, 0);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("fl_cleared", outValid, 0);
        tick();
        checkOutput("fl_nothing_leaked", outValid, 0);
        applyStimulus(1'b1, 8'sd2, 4'd8, 1'b1);
        checkOutput("fl_restart_ready", inReady, 1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1);
        tick();
        checkOutput("fl_restart_valid", outValid, 1);
        checkOutput("fl_restart_y", outY, refY(2, 8));
        checkOutput("fl_restart_frac", outFrac, 8);
        tick();

        // Asynchronous reset while the output is stalled.
        applyStimulus(1'b1, 8'sd5, 4'd3, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        tick();
        checkOutput("ar_pre_valid", outValid, 1);
        checkOutput("ar_pre_y", outY, 300);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", outValid, 0);
        checkOutput("ar_y", outY, 0);
        checkOutput("ar_frac", outFrac, 0);
        #3;
        rst_n = 1'b1;
        tick();
        checkOutput("ar_in_ready", inReady, 1);
        applyStimulus(1'b1, -8'sd7, 4'd11, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1);
        tick();
        checkOutput("ar_after_valid", outValid, 1);
        checkOutput("ar_after_y", outY, -182);
        checkOutput("ar_after_frac", outFrac, 11);
        checkOutput("ar_after_neg_y", outYN, 182);
        tick();

        // Randomized traffic on the wider instance, then a bounded drain.
        for (int k = 0; k < 600; k++) randCycle(1'b0);
        for (int k = 0; k < 20 && (expQ.size() != 0 || rOutValid); k++) randCycle(1'b1);
        checkOutput("rand_queue_empty", expQ.size(), 0);
        checkOutput("rand_count", nOut, nIn);
        checkOutput("rand_final_valid", rOutValid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
